// File: rtl/lpm_counter_sched.sv
// Round-robin scheduler sharing one down-counting interval timer among
// lpm_nreq requesters; the owner gets a one-cycle done pulse at terminal count.
module lpm_counter_sched #(
  parameter int lpm_width = 8,
  parameter int lpm_nreq  = 4,
  parameter     lpm_hint  = "UNUSED"
) (
  input  logic                          clock,
  input  logic                          aclr,
  input  logic                          clk_en,
  input  logic [lpm_nreq-1:0]           req,
  input  logic [lpm_nreq*lpm_width-1:0] data,
  output logic [lpm_nreq-1:0]           grant,
  output logic                          busy,
  output logic [lpm_width-1:0]          q,
  output logic                          cout,
  output logic [lpm_nreq-1:0]           done
);

  localparam int PW = (lpm_nreq > 1) ? $clog2(lpm_nreq) : 1;
  localparam logic [lpm_width-1:0] ONE = lpm_width'(1);
  localparam logic [PW-1:0] LAST = PW'(lpm_nreq - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [lpm_nreq-1:0]   grant_q, grant_d;
  logic [lpm_nreq-1:0]   done_q, done_d;
  logic [lpm_width-1:0]  q_q, q_d;
  logic                  busy_q, busy_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         own_q, own_d;

  logic                  found;
  logic [PW-1:0]         win;
  logic [lpm_nreq-1:0]   win_oh;
  logic [lpm_width-1:0]  load_val;
  logic [PW-1:0]         ptr_next;
  int unsigned           idx;

  // First requester at or after ptr, wrapping modulo lpm_nreq.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    idx    = 0;
    for (int unsigned i = 0; i < lpm_nreq; i++) begin
      idx = {{(32-PW){1'b0}}, ptr_q} + i;
      if (idx >= lpm_nreq) idx = idx - lpm_nreq;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    win_oh[win] = 1'b1;
    load_val    = data[win*lpm_width +: lpm_width];
  end

  assign ptr_next = (own_q == LAST) ? '0 : own_q + PW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = done_q;
    q_d     = q_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            own_d   = win;
            grant_d = win_oh;
            q_d     = load_val;
            busy_d  = 1'b1;
            if (load_val == '0) begin
              state_d = DONE;
              done_d  = win_oh;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (req[own_q]) begin
            q_d = q_q - ONE;
            if (q_q == ONE) begin
              state_d = DONE;
              done_d  = grant_q;
            end
          end else begin
            // Abort: q keeps its last value and no done is issued.
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = ptr_next;
          end
        end
        DONE: begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign q     = q_q;
  assign busy  = busy_q;
  assign cout  = (state_q == RUN) && (q_q == ONE);

endmodule

// File: tb/tb_lpm_counter_sched.sv
// Randomized self-checking bench for lpm_counter_sched against an
// owner/remaining-count reference model of the scheduling rules.
module tb_lpm_counter_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic             clock = 1'b0;
  logic             aclr;
  logic             clk_en;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data;
  logic [N-1:0]     grant;
  logic             busy;
  logic [W-1:0]     q;
  logic             cout;
  logic [N-1:0]     done;

  lpm_counter_sched #(.lpm_width(W), .lpm_nreq(N), .lpm_hint("UNUSED")) dut (
    .clock (clock),
    .aclr  (aclr),
    .clk_en(clk_en),
    .req   (req),
    .data  (data),
    .grant (grant),
    .busy  (busy),
    .q     (q),
    .cout  (cout),
    .done  (done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the timer (-1 = nobody), its value,
  // whether the owner is in its completion cycle, and the priority index.
  int m_owner;
  int m_q;
  int m_ptr;
  bit m_fin;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_q     = 0;
    m_ptr   = 0;
    m_fin   = 1'b0;
  endtask

  task automatic model_edge();
    bit got;
    int k;
    if (!clk_en) return;
    if (m_owner < 0) begin
      got = 1'b0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!got && req[k]) begin
          got     = 1'b1;
          m_owner = k;
          m_q     = int'(data[k*W +: W]);
          m_fin   = (m_q == 0);
        end
      end
    end else if (m_fin) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_fin   = 1'b0;
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_q = m_q - 1;
      if (m_q == 0) m_fin = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check_eq("grant", 64'(grant), 64'(eg));
    check_eq("busy",  64'(busy),  64'(m_owner >= 0));
    check_eq("q",     64'(q),     64'(m_q));
    check_eq("done",  64'(done),  m_fin ? 64'(eg) : 64'd0);
    check_eq("cout",  64'(cout),  64'(m_owner >= 0 && !m_fin && m_q == 1));
  endtask

  // Inputs are changed only between steps, i.e. after a falling edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_outputs();
    @(negedge clock);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clock);
    #1;
    compare_outputs();
    @(negedge clock);
    aclr = 1'b0;
  endtask

  // Owners release their request in the completion cycle.
  task automatic step_auto(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (m_fin) req[m_owner] = 1'b0;
    end
  endtask

  int order[$];
  logic [N-1:0] prev_grant;

  initial begin
    aclr   = 1'b0;
    clk_en = 1'b1;
    req    = '0;
    data   = '0;
    model_reset();
    @(negedge clock);

    // Reset and idle.
    do_reset();
    step();
    step();

    // Single requester with load 3.
    data[1*W +: W] = 8'd3;
    req = 4'b0010;
    step();
    check_eq("t2_grant", 64'(grant), 64'b0010);
    check_eq("t2_load",  64'(q), 64'd3);
    step();
    step();
    check_eq("t2_cout", 64'(cout), 64'd1);
    step();
    check_eq("t2_done", 64'(done), 64'b0010);
    req = '0;
    step();
    step();

    // Fairness from a fresh pointer: all requesting, loads of 2.
    do_reset();
    for (int k = 0; k < N; k++) data[k*W +: W] = 8'd2;
    req = '1;
    prev_grant = '0;
    for (int c = 0; c < 20; c++) begin
      step_auto(1);
      if (prev_grant == '0 && grant != '0)
        for (int k = 0; k < N; k++) if (grant[k]) order.push_back(k);
      prev_grant = grant;
    end
    check_eq("t3_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size() && i < N; i++) check_eq("t3_order", 64'(order[i]), 64'(i));

    // Zero load: straight to completion.
    req = 4'b0100;
    data[2*W +: W] = 8'd0;
    step();
    check_eq("t4_grant", 64'(grant), 64'b0100);
    check_eq("t4_done",  64'(done),  64'b0100);
    check_eq("t4_cout",  64'(cout),  64'd0);
    req = '0;
    step();

    // Abort mid-run, then rotated priority.
    data[0 +: W] = 8'd7;
    req = 4'b0001;
    step();
    step();
    step();
    check_eq("t5_q", 64'(q), 64'd5);
    req = '0;
    step();
    check_eq("t5_nodone", 64'(done), 64'd0);
    req = 4'b0011;
    step();
    check_eq("t5_winner", 64'(grant), 64'b0010);
    req[0] = 1'b0;
    step_auto(8);

    // Stall with clk_en low, then asynchronous clear mid-run.
    req = 4'b0100;
    data[2*W +: W] = 8'd6;
    step();
    step();
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_frozen", 64'(q), 64'd4);
    end
    do_reset();
    check_eq("t6_clear_q", 64'(q), 64'd0);
    clk_en = 1'b1;
    req = '1;
    step();
    check_eq("t6_ptr0", 64'(grant), 64'b0001);
    req = '0;
    step_auto(8);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      clk_en = ($urandom_range(0, 99) < 85);
      for (int k = 0; k < N; k++) begin
        data[k*W +: W] = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
        if (k == m_owner && m_fin) begin
          if ($urandom_range(0, 9) != 0) req[k] = 1'b0;
        end else if (k == m_owner) begin
          if ($urandom_range(0, 99) < 3) req[k] = 1'b0;
        end else if (!req[k]) begin
          if ($urandom_range(0, 99) < 30) req[k] = 1'b1;
        end else begin
          if ($urandom_range(0, 99) < 10) req[k] = 1'b0;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
